// File: rtl/fbuf_port_arbiter.sv
// Single-port frame-buffer arbiter: the display reader always owns the RAM slot,
// and camera writes queue in a small FIFO that drains whenever no read is requested.
module fbuf_port_arbiter #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 12,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_valid,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ready,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [15:0]        stall_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {GRANT_IDLE, GRANT_READ, GRANT_WRITE} grant_t;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [FIFO_AW:0]  wptr;
    logic [FIFO_AW:0]  rptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              rd_pend;
    grant_t            grant;

    assign full       = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                        (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign empty      = (wptr == rptr);
    assign wr_ready   = !full;
    assign fifo_level = wptr - rptr;

    // A write accepted during flush is dropped, and flush also blocks the pop.
    assign push = wr_valid && !full && !flush;
    assign pop  = !rd_req && !empty && !flush;

    always_comb begin
        grant = GRANT_IDLE;
        if (rd_req)
            grant = GRANT_READ;
        else if (pop)
            grant = GRANT_WRITE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr[FIFO_AW-1:0]] <= wr_addr;
            fifo_data[wptr[FIFO_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (flush)
                rptr <= wptr;
            else if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    // RAM port registers; address and write data hold their last value when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (grant)
                GRANT_READ: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= rd_addr;
                end
                GRANT_WRITE: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= fifo_addr[rptr[FIFO_AW-1:0]];
                    mem_wdata <= fifo_data[rptr[FIFO_AW-1:0]];
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_pend  <= mem_en && !mem_we;
            rd_valid <= rd_pend;
            if (rd_pend)
                rd_data <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (flush)
            stall_cnt <= '0;
        else if (wr_valid && full && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule
